id_uop_seq: RTL and testbench
=============================

# id_uop_seq

Registered decode front end that splits block-transfer and swap instructions into single-register micro-ops (uops). It accepts one condition-qualified instruction per handshake and emits a stream of uops toward the operand/execute path. LDM/STM expands into one uop per listed register; SWP expands into a load uop followed by a store uop. All other instructions pass through as one uop. This block generalises the combinational decode to a parametrised, stallable, multi-cycle sequencer.

## Interface
- NREG, 16: register-list width (8 or 16); only i_inst[NREG-1:0] is scanned.
- ADDR_W, 32: address/base width.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_inst_vld  in  1  instruction offered.
- i_inst  in  32  instruction word.
- i_nzcv  in  4  flags {N,Z,C,V} used for the condition check.
- i_rn_reg  in  ADDR_W  value of Rn (i_inst[19:16]), sampled at accept.
- o_inst_rdy  out  1  instruction accepted when i_inst_vld & o_inst_rdy.
- i_flush  in  1  squash all held/pending uops.
- o_uop_vld  out  1  uop valid.
- i_uop_rdy  in  1  downstream takes uop when o_uop_vld & i_uop_rdy.
- o_uop_kind  out  2  0 SINGLE, 1 XFER (LDM/STM beat), 2 SWP_LD, 3 SWP_ST.
- o_uop_inst  out  32  original instruction (all kinds).
- o_uop_reg  out  4  register transferred (XFER/SWP); 0 for SINGLE.
- o_uop_addr  out  ADDR_W  memory address (XFER/SWP); 0 for SINGLE.
- o_uop_load  out  1  1 = load, 0 = store.
- o_uop_byte  out  1  byte access (SWPB only).
- o_uop_last  out  1  final uop of the instruction.
- o_wb_vld  out  1  base writeback valid (XFER last beat only, W=1).
- o_wb_code  out  4  base register code.
- o_wb_val  out  ADDR_W  writeback value.
- o_busy  out  1  state != IDLE.

## Operation
- Condition check: standard 16-entry table on i_inst[31:28] (EQ..LE, AL true, NV false). Failed condition: instruction consumed, no uop emitted.
- Classes: LDM/STM when i_inst[27:25]=100; SWP when {[27:23],[21:20],[11:4]}=00010_00_00001001; everything else SINGLE.
- States: IDLE, XFER, SWP_ST.
- o_inst_rdy = (state==IDLE) & (!o_uop_vld | i_uop_rdy) & !i_flush.
- SINGLE: one uop, o_uop_last=1, stays IDLE.
- LDM/STM: cnt = popcount(list), P=[24], U=[23], W=[21], L=[20]. Start address: IA Rn; IB Rn+4; DA Rn-4*cnt+4; DB Rn-4*cnt. Beats in ascending register order (lowest set bit first), address +4 per beat. o_uop_load=L. Writeback value Rn+4*cnt (U=1) or Rn-4*cnt (U=0), presented with last beat when W=1. cnt=1: single beat, stays IDLE. cnt>1: enter XFER; leave to IDLE when the last beat is taken.
- Empty list: consumed, no uop, no writeback.
- SWP: SWP_LD {reg=Rd[15:12], addr=Rn, load=1, last=0}, then SWP_ST {reg=Rm[3:0], addr=Rn, load=0, last=1}; o_uop_byte=[22] on both.
- Remaining-list register clears one bit per accepted beat; last = exactly one bit remaining.
- Address arithmetic modulo 2^ADDR_W; count width clog2(NREG+1).
- i_flush: next edge clears o_uop_vld, o_wb_vld, returns IDLE; takes priority over a simultaneous accept or beat advance.

## Timing
- Reset: state IDLE; o_uop_vld=0, o_wb_vld=0, o_busy=0, all uop/wb data outputs 0; o_inst_rdy=1 in the first cycle after reset (if no flush).
- Accept at edge t -> first uop valid after edge t (cycle t+1). Zero-bubble: N-register LDM occupies N consecutive cycles with i_uop_rdy=1; SWP occupies 2.
- Stall: while o_uop_vld & !i_uop_rdy, all o_uop_*/o_wb_* hold stable and state does not advance.
- Back-to-back: a new instruction is accepted in the same cycle the last uop is taken.

## Test plan
- Reset, then ADD AL (0xE0811002), rdy=1 -> one SINGLE uop at t+1, last=1, inst echoed, busy=0.
- LDMIA R0!, {R1,R3,R5} (0xE8B0002A), Rn=0x1000 -> XFER beats reg 1/3/5 at 0x1000/0x1004/0x1008, load=1, last on 3rd, wb R0=0x100C.
- STMDB R13!, {R4,R14} (0xE92D4010), Rn=0x2000, i_uop_rdy toggled 1,0,1 -> regs 4,14 at 0x1FF8,0x1FFC, outputs held during stall, wb 0x1FF8.
- SWPB R2,R3,[R4] (0xE1442093), Rn=0x3001 -> SWP_LD reg 2 addr 0x3001 byte=1, then SWP_ST reg 3 addr 0x3001 last=1.
- BEQ with Z=0 -> consumed, no uop; LDMIA empty list -> consumed, no uop.
- LDMIA with 4 regs, assert i_flush after beat 2 -> o_uop_vld=0 next cycle, IDLE, no wb; i_rst mid-XFER -> all outputs 0.

Source files
------------

// File: rtl/id_uop_seq.sv
// id_uop_seq: decode front end that expands LDM/STM into one uop per listed
// register and SWP into a load/store uop pair. All other instructions pass
// through as a single uop. Every uop and writeback output is registered.
module id_uop_seq #(
  parameter int NREG   = 16,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inst_vld,
  input  logic [31:0]       i_inst,
  input  logic [3:0]        i_nzcv,
  input  logic [ADDR_W-1:0] i_rn_reg,
  output logic              o_inst_rdy,
  input  logic              i_flush,
  output logic              o_uop_vld,
  input  logic              i_uop_rdy,
  output logic [1:0]        o_uop_kind,
  output logic [31:0]       o_uop_inst,
  output logic [3:0]        o_uop_reg,
  output logic [ADDR_W-1:0] o_uop_addr,
  output logic              o_uop_load,
  output logic              o_uop_byte,
  output logic              o_uop_last,
  output logic              o_wb_vld,
  output logic [3:0]        o_wb_code,
  output logic [ADDR_W-1:0] o_wb_val,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(NREG + 1);

  localparam logic [1:0] KIND_SINGLE = 2'd0;
  localparam logic [1:0] KIND_XFER   = 2'd1;
  localparam logic [1:0] KIND_SWP_LD = 2'd2;
  localparam logic [1:0] KIND_SWP_ST = 2'd3;

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
  localparam logic [NREG-1:0]   LIST_ONE   = NREG'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    SWP_ST = 2'd2
  } state_e;

  // Standard ARM condition table over {N,Z,C,V}.
  function automatic logic condPass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = flags;
    case (cond)
      4'h0:    pass = z;
      4'h1:    pass = !z;
      4'h2:    pass = c;
      4'h3:    pass = !c;
      4'h4:    pass = n;
      4'h5:    pass = !n;
      4'h6:    pass = v;
      4'h7:    pass = !v;
      4'h8:    pass = c && !z;
      4'h9:    pass = !c || z;
      4'hA:    pass = (n == v);
      4'hB:    pass = (n != v);
      4'hC:    pass = !z && (n == v);
      4'hD:    pass = z || (n != v);
      4'hE:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  function automatic logic [CNT_W-1:0] popCount(input logic [NREG-1:0] list);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + CNT_W'(list[i]);
    end
    return cnt;
  endfunction

  // Index of the lowest set bit; beats go out in ascending register order.
  function automatic logic [3:0] lowIdx(input logic [NREG-1:0] list);
    logic [3:0] idx;
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (list[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_e            state_q, state_d;
  logic              uopVld_q, uopVld_d;
  logic [1:0]        uopKind_q, uopKind_d;
  logic [31:0]       uopInst_q, uopInst_d;
  logic [3:0]        uopReg_q, uopReg_d;
  logic [ADDR_W-1:0] uopAddr_q, uopAddr_d;
  logic              uopLoad_q, uopLoad_d;
  logic              uopByte_q, uopByte_d;
  logic              uopLast_q, uopLast_d;
  logic              wbVld_q, wbVld_d;
  logic [3:0]        wbCode_q, wbCode_d;
  logic [ADDR_W-1:0] wbVal_q, wbVal_d;
  logic [NREG-1:0]   remList_q, remList_d;

  logic              instRdy;
  logic              instAccept;
  logic              uopTaken;
  logic              condOk;
  logic              isLdm;
  logic              isSwp;
  logic [NREG-1:0]   listIn;
  logic [CNT_W-1:0]  cntIn;
  logic [ADDR_W-1:0] cntBytes;
  logic [ADDR_W-1:0] startAddr;
  logic [ADDR_W-1:0] wbValIn;
  logic [NREG-1:0]   nextList;
  logic              nextIsLast;

  assign instRdy    = (state_q == IDLE) && (!uopVld_q || i_uop_rdy) && !i_flush;
  assign instAccept = i_inst_vld && instRdy;
  assign uopTaken   = uopVld_q && i_uop_rdy;

  assign condOk   = condPass(i_inst[31:28], i_nzcv);
  assign isLdm    = (i_inst[27:25] == 3'b100);
  assign isSwp    = ({i_inst[27:23], i_inst[21:20], i_inst[11:4]} == 15'b00010_00_00001001);
  assign listIn   = i_inst[NREG-1:0];
  assign cntIn    = popCount(listIn);
  assign cntBytes = ADDR_W'(cntIn) << 2;
  assign wbValIn  = i_inst[23] ? (i_rn_reg + cntBytes) : (i_rn_reg - cntBytes);

  // Start address from the P/U addressing mode: IA, IB, DA, DB.
  always_comb begin
    startAddr = i_rn_reg;
    case ({i_inst[24], i_inst[23]})
      2'b01:   startAddr = i_rn_reg;
      2'b11:   startAddr = i_rn_reg + WORD_BYTES;
      2'b00:   startAddr = i_rn_reg - cntBytes + WORD_BYTES;
      default: startAddr = i_rn_reg - cntBytes;
    endcase
  end

  // Remaining list after the current beat retires, and whether one bit is left.
  assign nextList   = remList_q & (remList_q - LIST_ONE);
  assign nextIsLast = (nextList & (nextList - LIST_ONE)) == '0;

  // Next-state and next-uop selection; flush overrides everything else.
  always_comb begin
    state_d   = state_q;
    uopVld_d  = uopVld_q;
    uopKind_d = uopKind_q;
    uopInst_d = uopInst_q;
    uopReg_d  = uopReg_q;
    uopAddr_d = uopAddr_q;
    uopLoad_d = uopLoad_q;
    uopByte_d = uopByte_q;
    uopLast_d = uopLast_q;
    wbVld_d   = wbVld_q;
    wbCode_d  = wbCode_q;
    wbVal_d   = wbVal_q;
    remList_d = remList_q;

    case (state_q)
      IDLE: begin
        if (uopTaken) begin
          uopVld_d = 1'b0;
          wbVld_d  = 1'b0;
        end
        if (instAccept && condOk) begin
          if (isLdm) begin
            if (cntIn != '0) begin
              uopVld_d  = 1'b1;
              uopKind_d = KIND_XFER;
              uopInst_d = i_inst;
              uopReg_d  = lowIdx(listIn);
              uopAddr_d = startAddr;
              uopLoad_d = i_inst[20];
              uopByte_d = 1'b0;
              uopLast_d = (cntIn == CNT_W'(1));
              remList_d = listIn;
              wbCode_d  = i_inst[19:16];
              wbVal_d   = wbValIn;
              wbVld_d   = (cntIn == CNT_W'(1)) && i_inst[21];
              state_d   = (cntIn == CNT_W'(1)) ? IDLE : XFER;
            end
          end else if (isSwp) begin
            uopVld_d  = 1'b1;
            uopKind_d = KIND_SWP_LD;
            uopInst_d = i_inst;
            uopReg_d  = i_inst[15:12];
            uopAddr_d = i_rn_reg;
            uopLoad_d = 1'b1;
            uopByte_d = i_inst[22];
            uopLast_d = 1'b0;
            wbVld_d   = 1'b0;
            state_d   = SWP_ST;
          end else begin
            uopVld_d  = 1'b1;
            uopKind_d = KIND_SINGLE;
            uopInst_d = i_inst;
            uopReg_d  = '0;
            uopAddr_d = '0;
            uopLoad_d = 1'b0;
            uopByte_d = 1'b0;
            uopLast_d = 1'b1;
            wbVld_d   = 1'b0;
          end
        end
      end

      XFER: begin
        if (uopTaken) begin
          if (uopLast_q) begin
            uopVld_d = 1'b0;
            wbVld_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            remList_d = nextList;
            uopReg_d  = lowIdx(nextList);
            uopAddr_d = uopAddr_q + WORD_BYTES;
            uopLast_d = nextIsLast;
            wbVld_d   = nextIsLast && uopInst_q[21];
          end
        end
      end

      SWP_ST: begin
        if (uopTaken) begin
          if (uopLast_q) begin
            uopVld_d = 1'b0;
            state_d  = IDLE;
          end else begin
            uopKind_d = KIND_SWP_ST;
            uopReg_d  = uopInst_q[3:0];
            uopLoad_d = 1'b0;
            uopLast_d = 1'b1;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        uopVld_d = 1'b0;
        wbVld_d  = 1'b0;
      end
    endcase

    if (i_flush) begin
      state_d  = IDLE;
      uopVld_d = 1'b0;
      wbVld_d  = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      uopVld_q  <= 1'b0;
      uopKind_q <= '0;
      uopInst_q <= '0;
      uopReg_q  <= '0;
      uopAddr_q <= '0;
      uopLoad_q <= 1'b0;
      uopByte_q <= 1'b0;
      uopLast_q <= 1'b0;
      wbVld_q   <= 1'b0;
      wbCode_q  <= '0;
      wbVal_q   <= '0;
      remList_q <= '0;
    end else begin
      state_q   <= state_d;
      uopVld_q  <= uopVld_d;
      uopKind_q <= uopKind_d;
      uopInst_q <= uopInst_d;
      uopReg_q  <= uopReg_d;
      uopAddr_q <= uopAddr_d;
      uopLoad_q <= uopLoad_d;
      uopByte_q <= uopByte_d;
      uopLast_q <= uopLast_d;
      wbVld_q   <= wbVld_d;
      wbCode_q  <= wbCode_d;
      wbVal_q   <= wbVal_d;
      remList_q <= remList_d;
    end
  end

  assign o_inst_rdy = instRdy;
  assign o_uop_vld  = uopVld_q;
  assign o_uop_kind = uopKind_q;
  assign o_uop_inst = uopInst_q;
  assign o_uop_reg  = uopReg_q;
  assign o_uop_addr = uopAddr_q;
  assign o_uop_load = uopLoad_q;
  assign o_uop_byte = uopByte_q;
  assign o_uop_last = uopLast_q;
  assign o_wb_vld   = wbVld_q;
  assign o_wb_code  = wbCode_q;
  assign o_wb_val   = wbVal_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_id_uop_seq.sv
// Testbench for id_uop_seq: expected uops are queued when an instruction is
// offered and popped/compared each time the DUT hands a uop downstream.
module tb_id_uop_seq;

  localparam logic [1:0] K_SINGLE = 2'd0;
  localparam logic [1:0] K_XFER   = 2'd1;
  localparam logic [1:0] K_SWP_LD = 2'd2;
  localparam logic [1:0] K_SWP_ST = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] inst;
    logic [3:0]  rg;
    logic [31:0] addr;
    logic        load;
    logic        byt;
    logic        last;
    logic        busy;
    logic        wbVld;
    logic [3:0]  wbCode;
    logic [31:0] wbVal;
  } uop_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_inst_vld;
  logic [31:0] i_inst;
  logic [3:0]  i_nzcv;
  logic [31:0] i_rn_reg;
  logic        o_inst_rdy;
  logic        i_flush;
  logic        o_uop_vld;
  logic        i_uop_rdy;
  logic [1:0]  o_uop_kind;
  logic [31:0] o_uop_inst;
  logic [3:0]  o_uop_reg;
  logic [31:0] o_uop_addr;
  logic        o_uop_load;
  logic        o_uop_byte;
  logic        o_uop_last;
  logic        o_wb_vld;
  logic [3:0]  o_wb_code;
  logic [31:0] o_wb_val;
  logic        o_busy;

  int   checks = 0;
  int   passed = 0;
  uop_t exp_q[$];

  id_uop_seq #(.NREG(16), .ADDR_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_inst_vld(i_inst_vld), .i_inst(i_inst),
    .i_nzcv(i_nzcv), .i_rn_reg(i_rn_reg), .o_inst_rdy(o_inst_rdy), .i_flush(i_flush),
    .o_uop_vld(o_uop_vld), .i_uop_rdy(i_uop_rdy), .o_uop_kind(o_uop_kind),
    .o_uop_inst(o_uop_inst), .o_uop_reg(o_uop_reg), .o_uop_addr(o_uop_addr),
    .o_uop_load(o_uop_load), .o_uop_byte(o_uop_byte), .o_uop_last(o_uop_last),
    .o_wb_vld(o_wb_vld), .o_wb_code(o_wb_code), .o_wb_val(o_wb_val), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic uop_t mk(input logic [1:0] kind, input logic [31:0] inst,
                              input logic [3:0] rg, input logic [31:0] addr,
                              input logic load, input logic byt, input logic last,
                              input logic busy, input logic wbVld,
                              input logic [3:0] wbCode, input logic [31:0] wbVal);
    uop_t u;
    u.kind = kind; u.inst = inst; u.rg = rg; u.addr = addr;
    u.load = load; u.byt = byt; u.last = last; u.busy = busy;
    u.wbVld = wbVld; u.wbCode = wbVld ? wbCode : 4'h0; u.wbVal = wbVld ? wbVal : 32'h0;
    return u;
  endfunction

  // One clock of stimulus: sample mid-cycle, report handshakes, drop vld after accept.
  task automatic step(output bit vld, output bit took, output bit acc, output uop_t obs);
    @(negedge i_clk); #1;
    vld        = o_uop_vld;
    took       = o_uop_vld && i_uop_rdy;
    acc        = i_inst_vld && o_inst_rdy;
    obs.kind   = o_uop_kind;
    obs.inst   = o_uop_inst;
    obs.rg     = o_uop_reg;
    obs.addr   = o_uop_addr;
    obs.load   = (o_uop_kind == K_SINGLE) ? 1'b0 : o_uop_load;
    obs.byt    = o_uop_byte;
    obs.last   = o_uop_last;
    obs.busy   = o_busy;
    obs.wbVld  = o_wb_vld;
    obs.wbCode = o_wb_vld ? o_wb_code : 4'h0;
    obs.wbVal  = o_wb_vld ? o_wb_val : 32'h0;
    @(posedge i_clk); #1;
    if (acc) i_inst_vld = 1'b0;
  endtask

  task automatic test_reset();
    logic [113:0] dataOut;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    dataOut = {o_uop_kind, o_uop_inst, o_uop_reg, o_uop_addr, o_uop_load,
               o_uop_byte, o_uop_last, o_wb_code, o_wb_val};
    checks++; if (o_uop_vld !== 1'b0) $display("[TB] FAIL reset_uop_vld: got %b expected 0", o_uop_vld); else passed++;
    checks++; if (o_wb_vld !== 1'b0) $display("[TB] FAIL reset_wb_vld: got %b expected 0", o_wb_vld); else passed++;
    checks++; if (o_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); else passed++;
    checks++; if (o_inst_rdy !== 1'b1) $display("[TB] FAIL reset_inst_rdy: got %b expected 1", o_inst_rdy); else passed++;
    checks++; if (dataOut !== '0) $display("[TB] FAIL reset_data: got %h expected 0", dataOut); else passed++;
  endtask

  task automatic test_single();
    bit vld, took, acc;
    uop_t obs, expv;
    int accCyc = -100, takeCyc = -1;
    exp_q.push_back(mk(K_SINGLE, 32'hE0811002, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0));
    i_inst = 32'hE0811002; i_nzcv = 4'h0; i_rn_reg = 32'h55; i_inst_vld = 1'b1;
    for (int c = 0; c < 20 && (i_inst_vld || exp_q.size() > 0); c++) begin
      step(vld, took, acc, obs);
      if (acc) accCyc = c;
      if (took) begin
        takeCyc = c;
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL single_extra: got %h expected none", obs);
        else begin
          expv = exp_q.pop_front();
          if (obs !== expv) $display("[TB] FAIL single_uop: got %h expected %h", obs, expv); else passed++;
        end
      end
    end
    checks++; if (exp_q.size() != 0 || i_inst_vld) $display("[TB] FAIL single_timeout: got %0d pending expected 0", exp_q.size()); else passed++;
    checks++; if (takeCyc - accCyc != 1) $display("[TB] FAIL single_latency: got %0d expected 1", takeCyc - accCyc); else passed++;
    exp_q.delete();
  endtask

  task automatic test_ldm();
    bit vld, took, acc;
    uop_t obs, expv;
    int accCyc = -100, takeCyc = -1;
    exp_q.push_back(mk(K_XFER, 32'hE8B0002A, 4'd1, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0));
    exp_q.push_back(mk(K_XFER, 32'hE8B0002A, 4'd3, 32'h1004, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0));
    exp_q.push_back(mk(K_XFER, 32'hE8B0002A, 4'd5, 32'h1008, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h100C));
    i_inst = 32'hE8B0002A; i_rn_reg = 32'h1000; i_inst_vld = 1'b1;
    for (int c = 0; c < 30 && (i_inst_vld || exp_q.size() > 0); c++) begin
      step(vld, took, acc, obs);
      if (acc) accCyc = c;
      if (took) begin
        takeCyc = c;
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL ldm_extra: got %h expected none", obs);
        else begin
          expv = exp_q.pop_front();
          if (obs !== expv) $display("[TB] FAIL ldm_uop: got %h expected %h", obs, expv); else passed++;
        end
      end
    end
    checks++; if (exp_q.size() != 0 || i_inst_vld) $display("[TB] FAIL ldm_timeout: got %0d pending expected 0", exp_q.size()); else passed++;
    checks++; if (takeCyc - accCyc != 3) $display("[TB] FAIL ldm_zero_bubble: got %0d cycles expected 3", takeCyc - accCyc); else passed++;
    step(vld, took, acc, obs);
    checks++; if (vld !== 1'b0 || obs.busy !== 1'b0) $display("[TB] FAIL ldm_idle_after: got vld=%b busy=%b expected 0 0", vld, obs.busy); else passed++;
    exp_q.delete();
  endtask

  task automatic test_stm_stall();
    bit vld, took, acc, started = 0;
    uop_t obs, expv;
    int k = 0;
    exp_q.push_back(mk(K_XFER, 32'hE92D4010, 4'd4,  32'h1FF8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hD, 32'h0));
    exp_q.push_back(mk(K_XFER, 32'hE92D4010, 4'd14, 32'h1FFC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hD, 32'h1FF8));
    i_inst = 32'hE92D4010; i_rn_reg = 32'h2000; i_inst_vld = 1'b1; i_uop_rdy = 1'b1;
    for (int c = 0; c < 30 && (i_inst_vld || exp_q.size() > 0); c++) begin
      if (started) begin
        i_uop_rdy = (k == 1) ? 1'b0 : 1'b1;
        k++;
      end
      step(vld, took, acc, obs);
      if (acc) started = 1;
      if (vld && !took && exp_q.size() > 0) begin
        checks++;
        if (obs !== exp_q[0]) $display("[TB] FAIL stm_stall_hold: got %h expected %h", obs, exp_q[0]); else passed++;
      end
      if (took) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL stm_extra: got %h expected none", obs);
        else begin
          expv = exp_q.pop_front();
          if (obs !== expv) $display("[TB] FAIL stm_uop: got %h expected %h", obs, expv); else passed++;
        end
      end
    end
    i_uop_rdy = 1'b1;
    checks++; if (exp_q.size() != 0 || i_inst_vld) $display("[TB] FAIL stm_timeout: got %0d pending expected 0", exp_q.size()); else passed++;
    exp_q.delete();
  endtask

  task automatic test_swp();
    bit vld, took, acc;
    uop_t obs, expv;
    int accCyc = -100, takeCyc = -1;
    exp_q.push_back(mk(K_SWP_LD, 32'hE1442093, 4'd2, 32'h3001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0));
    exp_q.push_back(mk(K_SWP_ST, 32'hE1442093, 4'd3, 32'h3001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0));
    i_inst = 32'hE1442093; i_rn_reg = 32'h3001; i_inst_vld = 1'b1;
    for (int c = 0; c < 20 && (i_inst_vld || exp_q.size() > 0); c++) begin
      step(vld, took, acc, obs);
      if (acc) accCyc = c;
      if (took) begin
        takeCyc = c;
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL swp_extra: got %h expected none", obs);
        else begin
          expv = exp_q.pop_front();
          if (obs !== expv) $display("[TB] FAIL swp_uop: got %h expected %h", obs, expv); else passed++;
        end
      end
    end
    checks++; if (exp_q.size() != 0 || i_inst_vld) $display("[TB] FAIL swp_timeout: got %0d pending expected 0", exp_q.size()); else passed++;
    checks++; if (takeCyc - accCyc != 2) $display("[TB] FAIL swp_cycles: got %0d expected 2", takeCyc - accCyc); else passed++;
    exp_q.delete();
  endtask

  // IB single beat without writeback, DA pair with writeback, DB wrapping below zero.
  task automatic test_ldm_modes();
    bit vld, took, acc;
    uop_t obs, expv;
    logic [31:0] insts [3];
    logic [31:0] rns   [3];
    insts[0] = 32'hE9920080; rns[0] = 32'h0400;
    insts[1] = 32'hE8310005; rns[1] = 32'h0010;
    insts[2] = 32'hE9330002; rns[2] = 32'h0000;
    exp_q.push_back(mk(K_XFER, insts[0], 4'd7, 32'h0404,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 32'h0));
    exp_q.push_back(mk(K_XFER, insts[1], 4'd0, 32'h000C,     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 32'h0));
    exp_q.push_back(mk(K_XFER, insts[1], 4'd2, 32'h0010,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 32'h0008));
    exp_q.push_back(mk(K_XFER, insts[2], 4'd1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 32'hFFFFFFFC));
    for (int n = 0; n < 3; n++) begin
      i_inst = insts[n]; i_rn_reg = rns[n]; i_inst_vld = 1'b1;
      for (int c = 0; c < 20 && i_inst_vld; c++) begin
        step(vld, took, acc, obs);
        if (took) begin
          checks++;
          if (exp_q.size() == 0) $display("[TB] FAIL modes_extra: got %h expected none", obs);
          else begin
            expv = exp_q.pop_front();
            if (obs !== expv) $display("[TB] FAIL modes_uop: got %h expected %h", obs, expv); else passed++;
          end
        end
      end
      checks++; if (i_inst_vld) $display("[TB] FAIL modes_accept: got vld=1 expected accept of %h", insts[n]); else passed++;
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step(vld, took, acc, obs);
      if (took) begin
        checks++;
        expv = exp_q.pop_front();
        if (obs !== expv) $display("[TB] FAIL modes_uop: got %h expected %h", obs, expv); else passed++;
      end
    end
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL modes_timeout: got %0d pending expected 0", exp_q.size()); else passed++;
    exp_q.delete();
  endtask

  // BEQ with Z=0 and an empty LDM are consumed silently; BNE with Z=0 issues.
  task automatic test_cond_empty();
    bit vld, took, acc;
    uop_t obs, expv;
    logic [31:0] insts [3];
    int spurious = 0;
    insts[0] = 32'h0A000010;
    insts[1] = 32'hE8900000;
    insts[2] = 32'h1A000010;
    exp_q.push_back(mk(K_SINGLE, insts[2], 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0));
    i_nzcv = 4'b0000; i_rn_reg = 32'h800;
    for (int n = 0; n < 3; n++) begin
      i_inst = insts[n]; i_inst_vld = 1'b1;
      for (int c = 0; c < 20 && i_inst_vld; c++) begin
        step(vld, took, acc, obs);
        if (took) begin
          checks++;
          if (exp_q.size() == 0) $display("[TB] FAIL cond_extra: got %h expected none", obs);
          else begin
            expv = exp_q.pop_front();
            if (obs !== expv) $display("[TB] FAIL cond_uop: got %h expected %h", obs, expv); else passed++;
          end
        end
      end
      checks++; if (i_inst_vld) $display("[TB] FAIL cond_accept: got vld=1 expected accept of %h", insts[n]); else passed++;
      if (n < 2) begin
        for (int c = 0; c < 3; c++) begin
          step(vld, took, acc, obs);
          if (vld) spurious++;
        end
      end
    end
    checks++; if (spurious != 0) $display("[TB] FAIL cond_no_uop: got %0d uop cycles expected 0", spurious); else passed++;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      step(vld, took, acc, obs);
      if (took) begin
        checks++;
        expv = exp_q.pop_front();
        if (obs !== expv) $display("[TB] FAIL cond_uop: got %h expected %h", obs, expv); else passed++;
      end
    end
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL cond_timeout: got %0d pending expected 0", exp_q.size()); else passed++;
    exp_q.delete();
  endtask

  task automatic test_flush();
    bit vld, took, acc;
    uop_t obs, expv;
    int leftover = 0;
    exp_q.push_back(mk(K_XFER, 32'hE890001E, 4'd1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0));
    exp_q.push_back(mk(K_XFER, 32'hE890001E, 4'd2, 32'h104, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0));
    i_inst = 32'hE890001E; i_rn_reg = 32'h100; i_inst_vld = 1'b1;
    for (int c = 0; c < 20 && (i_inst_vld || exp_q.size() > 0); c++) begin
      step(vld, took, acc, obs);
      if (took) begin
        checks++;
        expv = exp_q.pop_front();
        if (obs !== expv) $display("[TB] FAIL flush_uop: got %h expected %h", obs, expv); else passed++;
      end
    end
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL flush_timeout: got %0d pending expected 0", exp_q.size()); else passed++;
    i_uop_rdy = 1'b0; i_flush = 1'b1;
    step(vld, took, acc, obs);
    i_flush = 1'b0;
    checks++; if (o_uop_vld !== 1'b0) $display("[TB] FAIL flush_uop_vld: got %b expected 0", o_uop_vld); else passed++;
    checks++; if (o_busy !== 1'b0) $display("[TB] FAIL flush_busy: got %b expected 0", o_busy); else passed++;
    checks++; if (o_wb_vld !== 1'b0) $display("[TB] FAIL flush_wb_vld: got %b expected 0", o_wb_vld); else passed++;
    i_uop_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(vld, took, acc, obs);
      if (vld || obs.wbVld) leftover++;
    end
    checks++; if (leftover != 0) $display("[TB] FAIL flush_quiet: got %0d active cycles expected 0", leftover); else passed++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit vld, took, acc;
    uop_t obs, expv;
    logic [113:0] dataOut;
    exp_q.push_back(mk(K_XFER, 32'hE890001E, 4'd1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0));
    i_inst = 32'hE890001E; i_rn_reg = 32'h200; i_inst_vld = 1'b1;
    for (int c = 0; c < 20 && (i_inst_vld || exp_q.size() > 0); c++) begin
      step(vld, took, acc, obs);
      if (took) begin
        checks++;
        expv = exp_q.pop_front();
        if (obs !== expv) $display("[TB] FAIL rstmid_uop: got %h expected %h", obs, expv); else passed++;
      end
    end
    checks++; if (o_busy !== 1'b1) $display("[TB] FAIL rstmid_busy_before: got %b expected 1", o_busy); else passed++;
    i_uop_rdy = 1'b0; i_rst = 1'b1;
    step(vld, took, acc, obs);
    i_rst = 1'b0; i_uop_rdy = 1'b1;
    dataOut = {o_uop_kind, o_uop_inst, o_uop_reg, o_uop_addr, o_uop_load,
               o_uop_byte, o_uop_last, o_wb_code, o_wb_val};
    checks++; if ({o_uop_vld, o_wb_vld, o_busy} !== 3'b000) $display("[TB] FAIL rstmid_flags: got %b expected 000", {o_uop_vld, o_wb_vld, o_busy}); else passed++;
    checks++; if (dataOut !== '0) $display("[TB] FAIL rstmid_data: got %h expected 0", dataOut); else passed++;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit vld, took, acc;
    uop_t obs, expv;
    int accCyc[2];
    int nAcc = 0, takeCyc = -1;
    exp_q.push_back(mk(K_SINGLE, 32'hE0811002, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0));
    exp_q.push_back(mk(K_SINGLE, 32'hE0411002, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0));
    accCyc[0] = -100; accCyc[1] = 100;
    i_inst = 32'hE0811002; i_inst_vld = 1'b1;
    for (int c = 0; c < 20 && (i_inst_vld || exp_q.size() > 0); c++) begin
      step(vld, took, acc, obs);
      if (acc) begin
        if (nAcc < 2) accCyc[nAcc] = c;
        nAcc++;
        if (nAcc == 1) begin
          i_inst = 32'hE0411002; i_inst_vld = 1'b1;
        end
      end
      if (took) begin
        takeCyc = c;
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL b2b_extra: got %h expected none", obs);
        else begin
          expv = exp_q.pop_front();
          if (obs !== expv) $display("[TB] FAIL b2b_uop: got %h expected %h", obs, expv); else passed++;
        end
      end
    end
    checks++; if (accCyc[1] - accCyc[0] != 1) $display("[TB] FAIL b2b_accept_gap: got %0d expected 1", accCyc[1] - accCyc[0]); else passed++;
    checks++; if (takeCyc - accCyc[0] != 2) $display("[TB] FAIL b2b_span: got %0d expected 2", takeCyc - accCyc[0]); else passed++;
    exp_q.delete();
  endtask

  // Hard stop in case some wait never resolves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Run every scenario in order and report.
  initial begin
    i_rst = 1'b1; i_inst_vld = 1'b0; i_inst = 32'h0; i_nzcv = 4'h0;
    i_rn_reg = 32'h0; i_flush = 1'b0; i_uop_rdy = 1'b1;
    test_reset();
    test_single();
    test_ldm();
    test_stm_stall();
    test_swp();
    test_ldm_modes();
    test_cond_empty();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
